// File: rtl/stack_engine.sv
// Parametrised operand stack: pop-N-then-push ops, registered top-two and peek
// read ports, occupancy count and sticky overflow/underflow flags.
module stack_engine #(
  parameter int unsigned DATA_W = 35,
  parameter int unsigned ADDR_W = 11
) (
  input  logic              clk,
  input  logic              rst_b,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  input  logic [ADDR_W:0]   pop_n,
  input  logic [ADDR_W-1:0] peek_off,
  input  logic              err_clr,
  output logic [DATA_W-1:0] top_0,
  output logic [DATA_W-1:0] top_1,
  output logic [DATA_W-1:0] peek_data,
  output logic [ADDR_W:0]   count,
  output logic              empty,
  output logic              full,
  output logic              overflow,
  output logic              underflow
);

  localparam int unsigned     DEPTH     = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] DEPTH_CNT = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] CNT_ONE   = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W:0] CNT_TWO   = CNT_ONE + CNT_ONE;

  logic [DATA_W-1:0] mem [DEPTH];

  logic              we;
  logic              ovf_ev;
  logic              unf_ev;
  logic [ADDR_W:0]   cnt_nxt;
  logic [ADDR_W-1:0] wr_idx;
  logic [DATA_W-1:0] top_0_nxt;
  logic [DATA_W-1:0] top_1_nxt;
  logic [ADDR_W:0]   peek_ext;
  logic              peek_valid;
  logic [ADDR_W-1:0] peek_idx;

  assign empty = (count == '0);
  assign full  = (count == DEPTH_CNT);

  // Any accepted push lands on the new top, so the write index is always cnt_nxt-1.
  always_comb begin
    we      = 1'b0;
    ovf_ev  = 1'b0;
    unf_ev  = 1'b0;
    cnt_nxt = count;
    if (pop) begin
      if (pop_n > count) begin
        unf_ev = 1'b1;
      end else if (push && (pop_n == '0) && full) begin
        ovf_ev = 1'b1;
      end else begin
        cnt_nxt = count - pop_n;
        if (push) begin
          cnt_nxt = cnt_nxt + CNT_ONE;
          we      = 1'b1;
        end
      end
    end else if (push) begin
      if (full) begin
        ovf_ev = 1'b1;
      end else begin
        cnt_nxt = count + CNT_ONE;
        we      = 1'b1;
      end
    end
  end

  assign wr_idx = ADDR_W'(cnt_nxt - CNT_ONE);

  // Entry below the new top is never the one being written, so no forwarding is needed there.
  always_comb begin
    top_0_nxt = '0;
    top_1_nxt = '0;
    if (we) begin
      top_0_nxt = push_data;
    end else if (cnt_nxt != '0) begin
      top_0_nxt = mem[wr_idx];
    end
    if (cnt_nxt >= CNT_TWO) begin
      top_1_nxt = mem[ADDR_W'(cnt_nxt - CNT_TWO)];
    end
  end

  assign peek_ext   = {1'b0, peek_off};
  assign peek_valid = (peek_ext < count);
  assign peek_idx   = ADDR_W'(count - CNT_ONE - peek_ext);

  always_ff @(posedge clk) begin
    if (we) begin
      mem[wr_idx] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      count     <= '0;
      top_0     <= '0;
      top_1     <= '0;
      peek_data <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      count     <= cnt_nxt;
      top_0     <= top_0_nxt;
      top_1     <= top_1_nxt;
      peek_data <= peek_valid ? mem[peek_idx] : '0;
      overflow  <= ovf_ev | (overflow & ~err_clr);
      underflow <= unf_ev | (underflow & ~err_clr);
    end
  end

endmodule

// File: doc/stack_engine.md
# stack_engine

Parametrised operand stack for the CPU datapath, the successor to the fixed 35-bit × 2048 operand stack. It adds configurable width and depth, a combined pop-N-then-push operation, occupancy reporting, sticky overflow/underflow detection with safe rejection, and a registered random-access peek port. It sits between instruction decode/execute and the operand path, supplying the two top entries to the ALU every cycle.

## Interface
- DATA_W, 35, entry width in bits
- ADDR_W, 11, log2 of depth; DEPTH = 2**ADDR_W entries
- clk  input  1  clock, all state on rising edge
- rst_b  input  1  asynchronous, active-low reset
- push  input  1  push push_data this cycle
- push_data  input  DATA_W  value to push
- pop  input  1  pop pop_n entries this cycle
- pop_n  input  ADDR_W+1  entries to pop, unsigned; 0 is a no-op pop
- peek_off  input  ADDR_W  peek offset from top (0 = top)
- err_clr  input  1  clear sticky error flags
- top_0  output  DATA_W  top entry (0 when count < 1)
- top_1  output  DATA_W  entry below top (0 when count < 2)
- peek_data  output  DATA_W  entry at peek_off (0 when peek_off >= count)
- count  output  ADDR_W+1  current occupancy, 0..DEPTH
- empty  output  1  count == 0
- full  output  1  count == DEPTH
- overflow  output  1  sticky: a push was rejected
- underflow  output  1  sticky: a pop was rejected

## Operation
- Storage: DEPTH × DATA_W array, not reset; entry i (0 = bottom) valid for i < count.
- Per edge, the operation is selected from pop, push and the current count (C):
  - idle (no pop, no push): no change.
  - push only: if C < DEPTH, write index C and set count = C+1. Otherwise reject, set overflow, and leave count/array unchanged.
  - pop only: if pop_n <= C, set count = C-pop_n. Otherwise reject, set underflow, and leave count unchanged.
  - pop+push (replace): pop first, then push. If pop_n <= C, write index C-pop_n and set count = C-pop_n+1.
    - pop_n = 0 with C = DEPTH is an overflow; reject the whole op.
    - pop_n > C is an underflow; reject the whole op, including the push.
- A rejected op writes nothing.
- top_0/top_1/peek_data read as 0 for invalid positions, never stale array contents.
- Sticky flags:
  - err_clr clears overflow and underflow.
  - A new error in the same cycle as err_clr wins, so the flag ends up 1.
- empty and full are decoded from the count register.

## Timing
- Reset (async assert, release sync to clk): count = 0, top_0 = 0, top_1 = 0, peek_data = 0, overflow = 0, underflow = 0, empty = 1, full = 0.
- Throughput: one op accepted every cycle; no stall or ready signal.
- top_0/top_1 are registered:
  - At edge E they take the post-op state of E.
  - push_data is forwarded when the push lands on the top, so pushing X at E gives top_0 = X after E.
- peek_data is registered:
  - At edge E it captures the entry at index C-1-peek_off from the pre-op state of E (one-cycle read latency).
  - There is no forwarding from the op at E.
- count, empty, full, overflow and underflow update at the op edge.
- Reset mid-operation: the op in flight is lost, count is forced to 0, and array contents are don't-care.

## Test plan
- Reset, then push 0x1, 0x2, 0x3 on consecutive cycles -> after each edge top_0 = 0x1/0x2/0x3, top_1 = 0/0x1/0x2, count = 1/2/3.
- With stack [0x1, 0x2, 0x3]:
  - pop with pop_n = 2 -> count = 1, top_0 = 0x1, top_1 = 0.
  - Next cycle, pop_n = 1 with push 0x7 -> count = 1, top_0 = 0x7.
- From empty, pop with pop_n = 1 and push 0x5 -> rejected: underflow = 1, count = 0, top_0 = 0.
  - Then err_clr alone -> underflow = 0.
- Fill to DEPTH (ADDR_W = 3 build, 8 entries) -> full = 1.
  - Push 0xA -> overflow = 1, count = 8, top_0 unchanged.
  - Then pop_n = 1 with push 0xA -> count = 8, top_0 = 0xA.
- With stack [0x1, 0x2, 0x3], peek_off = 0, 1, 2, 3 on successive idle cycles -> peek_data = 0x3, 0x2, 0x1, 0 one edge later.
- Assert rst_b low mid-stream with push active -> all outputs reach reset values immediately, without a clock edge.
  - After release, push 0x9 -> count = 1, top_0 = 0x9.
